// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned STREAK_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_e;

    // Request captured at grant time and held toward memory until completion.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic              wr;
        logic              dump;
        logic              both;   // rd and wr both requested: runs as write, flagged as error
    } mem_req_t;

    // Which port owns the memory in a given state.
    function automatic owner_e state_owner(input arb_state_e s);
        return (s == BUSY_D) ? OWNER_DM : OWNER_IF;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: flags the cycle in which a transaction has been busy TIMEOUT cycles.
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count busy cycles, saturating at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current busy cycle is the TIMEOUT-th one since the grant.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle unified memory between the fetch port and the data port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STREAK  = STREAK_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    output logic              if_err,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic              dm_dump,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              dm_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_dump,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_err
);

    localparam int unsigned STK_W = $clog2(STREAK + 1);

    arb_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [STK_W-1:0]  streak_q, streak_d;
    logic              grant_c;
    logic              busy_c;
    logic              wd_expired;
    logic              dm_req_c;
    logic              end_c;
    logic              end_err_c;
    logic [DATA_W-1:0] end_rdata_c;
    owner_e            owner_c;

    assign dm_req_c = dm_rd | dm_wr;
    assign busy_c   = (state_q != IDLE);

    // Next state, grant decision, request latch and fairness streak.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        streak_d = streak_q;
        grant_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req_c && !((streak_q == STK_W'(STREAK)) && if_req)) begin
                    state_d       = BUSY_D;
                    grant_c       = 1'b1;
                    req_d.addr    = dm_addr;
                    req_d.wdata   = dm_wdata;
                    req_d.rd      = dm_rd & ~dm_wr;
                    req_d.wr      = dm_wr;
                    req_d.dump    = dm_dump;
                    req_d.both    = dm_rd & dm_wr;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STK_W'(STREAK)) begin
                        streak_d = streak_q + STK_W'(1);
                    end
                end else if (if_req) begin
                    state_d       = BUSY_I;
                    grant_c       = 1'b1;
                    req_d.addr    = if_addr;
                    req_d.wdata   = '0;
                    req_d.rd      = 1'b1;
                    req_d.wr      = 1'b0;
                    req_d.dump    = 1'b0;
                    req_d.both    = 1'b0;
                    streak_d      = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_done || wd_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and streak registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            streak_q <= streak_d;
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant_c),
        .enable  (busy_c),
        .expired (wd_expired)
    );

    // Memory-side drive and per-port completion steering; normal completion beats timeout.
    always_comb begin
        owner_c     = state_owner(state_q);
        end_c       = busy_c && (mem_done || wd_expired);
        end_err_c   = mem_done ? (mem_err | req_q.both) : 1'b1;
        end_rdata_c = (mem_done && !req_q.wr) ? mem_rdata : '0;

        mem_rd      = busy_c & req_q.rd;
        mem_wr      = busy_c & req_q.wr;
        mem_dump    = busy_c & req_q.dump;
        mem_addr    = busy_c ? req_q.addr  : '0;
        mem_wdata   = busy_c ? req_q.wdata : '0;

        if_done     = end_c && (owner_c == OWNER_IF);
        dm_done     = end_c && (owner_c == OWNER_DM);
        if_err      = if_done & end_err_c;
        dm_err      = dm_done & end_err_c;
        if_rdata    = if_done ? end_rdata_c : '0;
        dm_rdata    = dm_done ? end_rdata_c : '0;

        // Stall is masked during reset so every output reads 0 while rst is low.
        if_stall    = rst & if_req & ~if_done;
        dm_stall    = rst & dm_req_c & ~dm_done;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a monitor pops and compares.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done, if_stall, if_err;
    logic        dm_rd, dm_wr, dm_dump;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_done, dm_stall, dm_err;
    logic        mem_rd, mem_wr, mem_dump;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_done, mem_err;

    typedef struct {
        bit          is_if;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    // Memory model knobs: lat = busy cycles until mem_done (0 = never).
    int          lat;
    int          busy_cnt;
    logic [15:0] rdata_v;
    logic        err_v;
    logic        model_done;
    logic        force_done;

    // Requester agents: hold a request until the given number of completions.
    int          if_left;
    int          dm_left;
    logic        if_done_s, dm_done_s;

    assign mem_done  = model_done | force_done;
    assign mem_rdata = rdata_v;
    assign mem_err   = err_v;

    mem_arbiter #(
        .STREAK  (4),
        .TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .if_err    (if_err),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_dump   (dm_dump),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .dm_stall  (dm_stall),
        .dm_err    (dm_err),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_dump  (mem_dump),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit is_if, input logic [15:0] rdata, input logic err);
        exp_t e;
        e.is_if = is_if;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Wait until both requesters have let go, bounded.
    task automatic wait_idle(input int maxc);
        bit done_w;
        done_w = 1'b0;
        for (int k = 0; k < maxc && !done_w; k++) begin
            @(negedge clk);
            if (!if_req && !dm_rd && !dm_wr) done_w = 1'b1;
        end
        if (!done_w) begin
            total_cnt++;
            $display("FAIL wait_idle: requests still pending after %0d cycles", maxc);
            if_req  = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; dm_dump = 1'b0;
            if_left = 0;    dm_left = 0;
        end
    endtask

    // Memory model: asserts mem_done in the lat-th consecutive busy cycle.
    always @(posedge clk) begin
        #1;
        if (mem_rd || mem_wr) begin
            busy_cnt++;
            model_done = (lat != 0) && (busy_cnt == lat);
        end else begin
            busy_cnt   = 0;
            model_done = 1'b0;
        end
    end

    // Capture done pulses mid-cycle for the requester agents.
    always @(negedge clk) begin
        if_done_s = if_done;
        dm_done_s = dm_done;
    end

    // Requester agents drop their request once the last expected completion arrives.
    always @(posedge clk) begin
        #1;
        if (if_done_s && if_left > 0) begin
            if_left--;
            if (if_left == 0) if_req = 1'b0;
        end
        if (dm_done_s && dm_left > 0) begin
            dm_left--;
            if (dm_left == 0) begin
                dm_rd = 1'b0; dm_wr = 1'b0; dm_dump = 1'b0;
            end
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (if_done || dm_done) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: if_done=%0b dm_done=%0b with nothing outstanding (t=%0t)",
                         if_done, dm_done, $time);
            end else begin
                e = sb.pop_front();
                chk("done_port", 32'({if_done, dm_done}), e.is_if ? 32'd2 : 32'd1);
                chk("done_rdata", 32'(e.is_if ? if_rdata : dm_rdata), 32'(e.rdata));
                chk("done_err", 32'(e.is_if ? if_err : dm_err), 32'(e.err));
                chk("other_port_rdata", 32'(e.is_if ? dm_rdata : if_rdata), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stim
        int  n;
        bit  seen;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_rd = 1'b0; dm_wr = 1'b0; dm_dump = 1'b0; dm_addr = '0; dm_wdata = '0;
        lat = 1; busy_cnt = 0; rdata_v = '0; err_v = 1'b0; model_done = 1'b0; force_done = 1'b0;
        if_left = 0; dm_left = 0; if_done_s = 1'b0; dm_done_s = 1'b0;

        // Reset state.
        #2;
        chk("rst_mem_ctrl", 32'({mem_rd, mem_wr, mem_dump}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_done", 32'({if_done, dm_done, if_stall, dm_stall}), 32'd0);
        @(posedge clk); #2 rst = 1'b1;

        // Single fetch, memory done in 3rd busy cycle.
        @(posedge clk); #2;
        lat = 3; rdata_v = 16'h1234; if_addr = 16'h0010;
        push_exp(1'b1, 16'h1234, 1'b0);
        if_left = 1; if_req = 1'b1;
        @(negedge clk);
        chk("f_stall_c0", 32'(if_stall), 32'd1);
        chk("f_memrd_c0", 32'(mem_rd), 32'd0);
        @(negedge clk);
        chk("f_memrd_c1", 32'(mem_rd), 32'd1);
        chk("f_addr_c1", 32'(mem_addr), 32'h0010);
        chk("f_stall_c1", 32'(if_stall), 32'd1);
        @(negedge clk);
        chk("f_memrd_c2", 32'(mem_rd), 32'd1);
        chk("f_stall_c2", 32'(if_stall), 32'd1);
        @(negedge clk);
        chk("f_done_c3", 32'(if_done), 32'd1);
        chk("f_memrd_c3", 32'(mem_rd), 32'd1);
        chk("f_stall_c3", 32'(if_stall), 32'd0);
        @(negedge clk);
        chk("f_after", 32'({if_done, mem_rd}), 32'd0);
        wait_idle(20);

        // Simultaneous fetch and data write: data first, fetch after one idle cycle.
        @(posedge clk); #2;
        lat = 2; rdata_v = 16'h7777;
        dm_addr = 16'h0040; dm_wdata = 16'hBEEF; if_addr = 16'h0100;
        push_exp(1'b0, 16'h0000, 1'b0);
        push_exp(1'b1, 16'h7777, 1'b0);
        dm_left = 1; dm_wr = 1'b1; if_left = 1; if_req = 1'b1;
        @(negedge clk);
        chk("c_dm_stall", 32'(dm_stall), 32'd1);
        @(negedge clk);
        chk("c_mem_ctrl", 32'({mem_rd, mem_wr}), 32'd1);
        chk("c_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("c_addr", 32'(mem_addr), 32'h0040);
        chk("c_if_stall", 32'(if_stall), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("c_idle_gap", 32'({mem_rd, mem_wr}), 32'd0);
        @(negedge clk);
        chk("c_if_grant", 32'(mem_rd), 32'd1);
        chk("c_if_addr", 32'(mem_addr), 32'h0100);
        wait_idle(20);

        // Fairness: data held with fetch pending gives 4 data grants, then fetch, then data.
        @(posedge clk); #2;
        lat = 1; rdata_v = 16'h0D0D; dm_addr = 16'h0080; if_addr = 16'h0104;
        for (int i = 0; i < 4; i++) push_exp(1'b0, 16'h0D0D, 1'b0);
        push_exp(1'b1, 16'h0D0D, 1'b0);
        push_exp(1'b0, 16'h0D0D, 1'b0);
        dm_left = 5; dm_rd = 1'b1; if_left = 1; if_req = 1'b1;
        wait_idle(100);

        // Watchdog: memory never completes.
        @(posedge clk); #2;
        lat = 0; rdata_v = 16'hFFFF; dm_addr = 16'h0200;
        push_exp(1'b0, 16'h0000, 1'b1);
        dm_left = 1; dm_rd = 1'b1;
        n = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (mem_rd) n++;
            if (dm_done) seen = 1'b1;
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL to_done: no dm_done within 100 cycles");
        end
        chk("to_busy_cycles", 32'(n), 32'd64);
        @(negedge clk);
        chk("to_memrd_drop", 32'(mem_rd), 32'd0);
        wait_idle(20);

        // Reset while BUSY_D: outputs clear at once, no done; then a fresh read.
        @(posedge clk); #2;
        lat = 0; dm_addr = 16'h0300;
        dm_left = 1; dm_rd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rs_busy", 32'(mem_rd), 32'd1);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        chk("rs_mem_ctrl", 32'({mem_rd, mem_wr, mem_dump}), 32'd0);
        chk("rs_mem_addr", 32'(mem_addr), 32'd0);
        chk("rs_dm_out", 32'({dm_done, dm_stall, dm_err}), 32'd0);
        dm_rd = 1'b0; dm_left = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2;
        lat = 2; rdata_v = 16'hCAFE; dm_addr = 16'h0310;
        push_exp(1'b0, 16'hCAFE, 1'b0);
        dm_left = 1; dm_rd = 1'b1;
        wait_idle(20);

        // Fetch with memory error, then mem_done while idle must be ignored.
        @(posedge clk); #2;
        lat = 2; err_v = 1'b1; rdata_v = 16'h5555; if_addr = 16'h0020;
        push_exp(1'b1, 16'h5555, 1'b1);
        if_left = 1; if_req = 1'b1;
        wait_idle(20);
        err_v = 1'b0;
        @(posedge clk); #2 force_done = 1'b1;
        @(negedge clk);
        chk("idle_done_ignored", 32'({if_done, dm_done}), 32'd0);
        chk("idle_mem_ctrl", 32'({mem_rd, mem_wr}), 32'd0);
        @(posedge clk); #2 force_done = 1'b0;

        // rd and wr together: runs as write with dump, flagged as error.
        @(posedge clk); #2;
        lat = 1; rdata_v = 16'h9999; dm_addr = 16'h0400; dm_wdata = 16'h1111;
        push_exp(1'b0, 16'h0000, 1'b1);
        dm_left = 1; dm_rd = 1'b1; dm_wr = 1'b1; dm_dump = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("both_mem_ctrl", 32'({mem_rd, mem_wr, mem_dump}), 32'd3);
        chk("both_wdata", 32'(mem_wdata), 32'h1111);
        wait_idle(20);

        @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
